// File: rtl/ssm_ctrl_pkg.sv
// Shared control package for the full-SSM datapath.
// State encoding, tiling defaults and width helpers.
package ssm_ctrl_pkg;

  localparam int unsigned DEF_H_TOTAL = 24;
  localparam int unsigned DEF_P_TOTAL = 64;
  localparam int unsigned DEF_N_TOTAL = 128;
  localparam int unsigned DEF_H_TILE  = 1;
  localparam int unsigned DEF_P_TILE  = 1;
  localparam int unsigned DEF_N_TILE  = 128;
  localparam int unsigned DEF_M_LAT   = 6;
  localparam int unsigned DEF_RD_LAT  = 1;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned cw(
    input int unsigned v
  );
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned head_tiles(
    input int unsigned h,
    input int unsigned ht
  );
    return h / ht;
  endfunction

  function automatic int unsigned n_tiles(
    input int unsigned h,
    input int unsigned p,
    input int unsigned n,
    input int unsigned ht,
    input int unsigned pt,
    input int unsigned nt
  );
    return (h / ht) * (p / pt) * (n / nt);
  endfunction

endpackage

// File: rtl/dah_tile_seq_tag_pipe.sv
// Valid+payload shift register with a mid and a tail tap.
// The mid payload is only carried as far as the mid tap.
module tag_pipe #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned TAP   = 1,
  parameter int unsigned MW    = 1,
  parameter int unsigned TW    = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          v_i,
  input  logic [MW-1:0] m_i,
  input  logic [TW-1:0] t_i,
  output logic          mid_v_o,
  output logic [MW-1:0] mid_o,
  output logic          tail_v_o,
  output logic [TW-1:0] tail_o
);

  logic [DEPTH-1:0]         vld_q;
  logic [TAP-1:0][MW-1:0]   m_q;
  logic [DEPTH-1:0][TW-1:0] t_q;

  // shift valid and payloads one stage per cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= '0;
      m_q   <= '0;
      t_q   <= '0;
    end else begin
      vld_q[0] <= v_i;
      m_q[0]   <= m_i;
      t_q[0]   <= t_i;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        t_q[k]   <= t_q[k-1];
      end
      for (int k = 1; k < TAP; k++) begin
        m_q[k] <= m_q[k-1];
      end
    end
  end

  assign mid_v_o  = vld_q[TAP-1];
  assign mid_o    = m_q[TAP-1];
  assign tail_v_o = vld_q[DEPTH-1];
  assign tail_o   = t_q[DEPTH-1];

endmodule

// File: rtl/dah_tile_seq.sv
// Tile sequencer for the dA*hprev multiplier array.
// Issues reads, aligns dA selection and write-back.
module dah_tile_seq
  import ssm_ctrl_pkg::*;
#(
  parameter int unsigned H_TOTAL = DEF_H_TOTAL,
  parameter int unsigned P_TOTAL = DEF_P_TOTAL,
  parameter int unsigned N_TOTAL = DEF_N_TOTAL,
  parameter int unsigned H_TILE  = DEF_H_TILE,
  parameter int unsigned P_TILE  = DEF_P_TILE,
  parameter int unsigned N_TILE  = DEF_N_TILE,
  parameter int unsigned M_LAT   = DEF_M_LAT,
  parameter int unsigned RD_LAT  = DEF_RD_LAT,
  localparam int unsigned HT =
    head_tiles(H_TOTAL, H_TILE),
  localparam int unsigned T =
    n_tiles(H_TOTAL, P_TOTAL, N_TOTAL,
            H_TILE, P_TILE, N_TILE),
  localparam int unsigned AW = cw(T),
  localparam int unsigned HW = cw(HT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_i,
  input  logic          hold_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          mul_valid_o,
  output logic [HW-1:0] h_idx_o,
  input  logic          mul_valid_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          err_o
);

  localparam int unsigned PT = P_TOTAL / P_TILE;
  localparam int unsigned NT = N_TOTAL / N_TILE;
  localparam int unsigned PN = PT * NT;
  localparam int unsigned D  = RD_LAT + M_LAT;
  localparam int unsigned FW = cw(D);
  localparam int unsigned IW = cw(D + 1) + 1;

  seq_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic [FW-1:0] flush_q;
  logic [IW-1:0] inf_q;
  logic [IW-1:0] inf_d;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          rd_en;
  logic          wr_en;
  logic          err_now;
  logic [HW-1:0] hidx;
  logic          tail_v;
  logic [AW-1:0] tail_a;

  assign rd_en = (state_q == ST_ISSUE) && !hold_i;
  assign hidx  = HW'(32'(cnt_q) / PN);

  tag_pipe #(
    .DEPTH (D),
    .TAP   (RD_LAT),
    .MW    (HW),
    .TW    (AW)
  ) u_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .v_i      (rd_en),
    .m_i      (hidx),
    .t_i      (cnt_q),
    .mid_v_o  (mul_valid_o),
    .mid_o    (h_idx_o),
    .tail_v_o (tail_v),
    .tail_o   (tail_a)
  );

  assign wr_en = (state_q != ST_FLUSH)
               && mul_valid_i && tail_v;

  // in-flight count: reads add, write-backs retire
  always_comb begin
    inf_d = inf_q;
    unique case (1'b1)
      (rd_en && !wr_en): inf_d = inf_q + 1'b1;
      (wr_en && !rd_en): inf_d = inf_q - 1'b1;
      default: ;
    endcase
  end

  // misaligned multiplier valid or start with work in flight
  always_comb begin
    err_now = 1'b0;
    if (state_q != ST_FLUSH) begin
      if (mul_valid_i != tail_v)
        err_now = 1'b1;
      if (state_q == ST_IDLE && start_i
          && inf_q != '0)
        err_now = 1'b1;
    end
  end

  // sequencer state, counters and registered flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      flush_q <= '0;
      inf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      inf_q <= inf_d;
      err_q <= err_q | err_now;
      unique case (state_q)
        ST_FLUSH: begin
          if (flush_q == FW'(D - 1))
            state_q <= ST_IDLE;
          else
            flush_q <= flush_q + 1'b1;
        end
        ST_IDLE: begin
          if (start_i) begin
            state_q <= ST_ISSUE;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (rd_en) begin
            if (cnt_q == AW'(T - 1)) begin
              state_q <= ST_DRAIN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (inf_d == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_FLUSH;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en;
  assign rd_addr_o = cnt_q;
  assign wr_en_o   = wr_en;
  assign wr_addr_o = tail_a;
  assign err_o     = err_q | err_now;

endmodule

// File: tb/tb_dah_tile_seq.sv
// Directed bench for dah_tile_seq, T=8 tiling.
// Multiplier model delays mul_valid_o by six cycles.
module tb_dah_tile_seq;

  logic       clk;
  logic       rstn;
  logic       start_i;
  logic       hold_i;
  logic       busy_o;
  logic       done_o;
  logic       rd_en_o;
  logic [2:0] rd_addr_o;
  logic       mul_valid_o;
  logic [0:0] h_idx_o;
  logic       mul_valid_i;
  logic       wr_en_o;
  logic [2:0] wr_addr_o;
  logic       err_o;

  logic       kill;
  logic       inj;
  logic [5:0] mdl_q = '0;

  int checks = 0;
  int errors = 0;

  logic       r_rd[64];
  logic [2:0] r_ra[64];
  logic       r_mv[64];
  logic       r_h[64];
  logic       r_wr[64];
  logic [2:0] r_wa[64];
  logic       r_busy[64];
  logic       r_done[64];
  logic       r_err[64];

  dah_tile_seq #(
    .H_TOTAL (2),
    .P_TOTAL (2),
    .N_TOTAL (4),
    .H_TILE  (1),
    .P_TILE  (1),
    .N_TILE  (2),
    .M_LAT   (6),
    .RD_LAT  (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .mul_valid_o (mul_valid_o),
    .h_idx_o     (h_idx_o),
    .mul_valid_i (mul_valid_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    mdl_q <= {mdl_q[4:0], mul_valid_o};

  assign mul_valid_i = (mdl_q[5] & ~kill) | inj;

  task automatic run(input int n, input int s2,
                     input int hl, input int hh,
                     input int ka, input int ra);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start_i = (k == 0) || (k == s2);
      hold_i  = (k >= hl) && (k <= hh);
      kill    = (k == ka);
      inj     = 1'b0;
      if (k == ra) rstn = 1'b0;
      #1;
      r_rd[k]   = rd_en_o;
      r_ra[k]   = rd_addr_o;
      r_mv[k]   = mul_valid_o;
      r_h[k]    = h_idx_o[0];
      r_wr[k]   = wr_en_o;
      r_wa[k]   = wr_addr_o;
      r_busy[k] = busy_o;
      r_done[k] = done_o;
      r_err[k]  = err_o;
    end
  endtask

  task automatic release_flush();
    for (int f = 0; f < 7; f++) begin
      @(posedge clk); #1;
      if (f == 0) rstn = 1'b1;
      start_i = 1'b0;
      hold_i  = 1'b0;
      kill    = 1'b0;
      inj     = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; hold_i = 1'b0;
    kill = 1'b0; inj = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({rd_en_o, rd_addr_o, mul_valid_o, h_idx_o,
         wr_en_o, wr_addr_o, busy_o, done_o, err_o}
        !== 13'd0) begin
      errors++;
      $display("FAIL reset outs got %b exp 0",
        {rd_en_o, rd_addr_o, mul_valid_o, h_idx_o,
         wr_en_o, wr_addr_o, busy_o, done_o, err_o});
    end
  endtask

  task automatic test_flush();
    for (int f = 0; f < 7; f++) begin
      @(posedge clk); #1;
      if (f == 0) rstn = 1'b1;
      inj     = (f == 2);
      start_i = (f == 3);
      #1;
      checks++;
      if ({wr_en_o, err_o, busy_o, rd_en_o} !== 4'b0)
      begin
        errors++;
        $display("FAIL flush f%0d wr/err/busy/rd got %b exp 0000",
          f, {wr_en_o, err_o, busy_o, rd_en_o});
      end
    end
  endtask

  task automatic test_basic(input string tag);
    logic e;
    run(18, -1, -1, -1, -1, -1);
    for (int k = 0; k < 18; k++) begin
      e = (k >= 1 && k <= 8);
      checks++;
      if (r_rd[k] !== e) begin
        errors++;
        $display("FAIL %s rd_en c%0d got %b exp %b",
          tag, k, r_rd[k], e);
      end
      if (e) begin
        checks++;
        if (r_ra[k] !== 3'(k - 1)) begin
          errors++;
          $display("FAIL %s rd_addr c%0d got %0d exp %0d",
            tag, k, r_ra[k], k - 1);
        end
      end
      e = (k >= 2 && k <= 9);
      checks++;
      if (r_mv[k] !== e) begin
        errors++;
        $display("FAIL %s mul_valid c%0d got %b exp %b",
          tag, k, r_mv[k], e);
      end
      if (e) begin
        checks++;
        if (r_h[k] !== 1'((k - 2) / 4)) begin
          errors++;
          $display("FAIL %s h_idx c%0d got %b exp %0d",
            tag, k, r_h[k], (k - 2) / 4);
        end
      end
      e = (k >= 8 && k <= 15);
      checks++;
      if (r_wr[k] !== e) begin
        errors++;
        $display("FAIL %s wr_en c%0d got %b exp %b",
          tag, k, r_wr[k], e);
      end
      if (e) begin
        checks++;
        if (r_wa[k] !== 3'(k - 8)) begin
          errors++;
          $display("FAIL %s wr_addr c%0d got %0d exp %0d",
            tag, k, r_wa[k], k - 8);
        end
      end
      e = (k == 16);
      checks++;
      if (r_done[k] !== e) begin
        errors++;
        $display("FAIL %s done c%0d got %b exp %b",
          tag, k, r_done[k], e);
      end
      e = (k >= 1 && k <= 16);
      checks++;
      if (r_busy[k] !== e) begin
        errors++;
        $display("FAIL %s busy c%0d got %b exp %b",
          tag, k, r_busy[k], e);
      end
      checks++;
      if (r_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL %s err c%0d got %b exp 0",
          tag, k, r_err[k]);
      end
    end
  endtask

  task automatic test_hold();
    logic e;
    int   ea;
    run(20, -1, 3, 4, -1, -1);
    for (int k = 0; k < 20; k++) begin
      e  = (k >= 1 && k <= 2) || (k >= 5 && k <= 10);
      ea = (k <= 2) ? k - 1 : k - 3;
      checks++;
      if (r_rd[k] !== e) begin
        errors++;
        $display("FAIL hold rd_en c%0d got %b exp %b",
          k, r_rd[k], e);
      end
      if (e) begin
        checks++;
        if (r_ra[k] !== 3'(ea)) begin
          errors++;
          $display("FAIL hold rd_addr c%0d got %0d exp %0d",
            k, r_ra[k], ea);
        end
      end
      e  = (k >= 8 && k <= 9) || (k >= 12 && k <= 17);
      ea = (k <= 9) ? k - 8 : k - 10;
      checks++;
      if (r_wr[k] !== e) begin
        errors++;
        $display("FAIL hold wr_en c%0d got %b exp %b",
          k, r_wr[k], e);
      end
      if (e) begin
        checks++;
        if (r_wa[k] !== 3'(ea)) begin
          errors++;
          $display("FAIL hold wr_addr c%0d got %0d exp %0d",
            k, r_wa[k], ea);
        end
      end
      e = (k == 18);
      checks++;
      if (r_done[k] !== e) begin
        errors++;
        $display("FAIL hold done c%0d got %b exp %b",
          k, r_done[k], e);
      end
    end
  endtask

  task automatic test_restart();
    int nw;
    int nd;
    nw = 0; nd = 0;
    run(18, 5, -1, -1, -1, -1);
    for (int k = 0; k < 18; k++) begin
      nw += int'(r_wr[k]);
      nd += int'(r_done[k]);
    end
    checks++;
    if (nw != 8) begin
      errors++;
      $display("FAIL restart wr count got %0d exp 8", nw);
    end
    checks++;
    if (nd != 1 || r_done[16] !== 1'b1) begin
      errors++;
      $display("FAIL restart done count %0d at16 %b exp 1/1",
        nd, r_done[16]);
    end
    checks++;
    if (r_busy[17] !== 1'b0 || r_err[17] !== 1'b0) begin
      errors++;
      $display("FAIL restart end busy/err got %b%b exp 00",
        r_busy[17], r_err[17]);
    end
  endtask

  task automatic test_fault();
    int nd;
    nd = 0;
    run(24, -1, -1, -1, 8, -1);
    for (int k = 0; k < 24; k++) nd += int'(r_done[k]);
    checks++;
    if (r_err[7] !== 1'b0) begin
      errors++;
      $display("FAIL fault err pre got %b exp 0", r_err[7]);
    end
    checks++;
    if (r_err[8] !== 1'b1) begin
      errors++;
      $display("FAIL fault err set got %b exp 1", r_err[8]);
    end
    checks++;
    if (r_err[23] !== 1'b1) begin
      errors++;
      $display("FAIL fault err sticky got %b exp 1", r_err[23]);
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL fault done count got %0d exp 0", nd);
    end
    @(posedge clk); #1;
    rstn = 1'b0; kill = 1'b0;
    @(posedge clk); #2;
    checks++;
    if ({err_o, busy_o} !== 2'b00) begin
      errors++;
      $display("FAIL fault err/busy after reset got %b exp 00",
        {err_o, busy_o});
    end
    release_flush();
  endtask

  task automatic test_midreset();
    int nd;
    nd = 0;
    run(10, -1, -1, -1, -1, 6);
    for (int k = 0; k < 10; k++) nd += int'(r_done[k]);
    for (int k = 7; k < 10; k++) begin
      checks++;
      if ({r_rd[k], r_ra[k], r_mv[k], r_h[k], r_wr[k],
           r_wa[k], r_busy[k], r_done[k], r_err[k]}
          !== 13'd0) begin
        errors++;
        $display("FAIL midrst outs c%0d got %b exp 0", k,
          {r_rd[k], r_ra[k], r_mv[k], r_h[k], r_wr[k],
           r_wa[k], r_busy[k], r_done[k], r_err[k]});
      end
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL midrst done count got %0d exp 0", nd);
    end
    release_flush();
    test_basic("post_rst");
  endtask

  initial begin
    test_reset();
    test_flush();
    test_basic("basic");
    test_hold();
    test_restart();
    test_fault();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule

// File: doc/dah_tile_seq.md
Name: dah_tile_seq

Overview:
Sequencer for the dA·hprev multiplier array in the full-SSM datapath. On start, it walks every (h,p,n) tile of the hidden state and issues one hprev tile read per cycle. It launches the multiplier with the matching head-tile index for dA selection and produces write-back strobes and addresses aligned to the multiplier output. It owns the post-reset flush, hold/stall, in-flight tracking, drain and done signalling. It sits between the state-memory read port, the dAh_mul array and the state-update write path.

Parameters:
H_TOTAL, 24, total heads
P_TOTAL, 64, total head-dim
N_TOTAL, 128, total state-dim
H_TILE, 1, heads per tile (must divide H_TOTAL)
P_TILE, 1, p per tile (must divide P_TOTAL)
N_TILE, 128, n per tile (must divide N_TOTAL)
M_LAT, 6, fixed multiplier latency in cycles
RD_LAT, 1, state-memory read latency in cycles (≥1)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
start_i  in  1  begin a full pass; accepted only in IDLE
hold_i  in  1  suppress new issues this cycle; in-flight work continues
busy_o  out  1  high from the cycle after start acceptance through the DONE cycle
done_o  out  1  one-cycle pulse at pass completion
rd_en_o  out  1  hprev tile read strobe
rd_addr_o  out  AW  tile address; AW = max(1, clog2(T))
mul_valid_o  out  1  to dAh_mul valid_i; rd_en_o delayed RD_LAT
h_idx_o  out  HW  head-tile index, aligned with mul_valid_o; HW = max(1, clog2(HT))
mul_valid_i  in  1  from dAh_mul valid_o
wr_en_o  out  1  write-back strobe for the dAh tile
wr_addr_o  out  AW  write-back tile address
err_o  out  1  sticky protocol error

Behaviour:
- Derived constants: HT=H_TOTAL/H_TILE, PT=P_TOTAL/P_TILE, NT=N_TOTAL/N_TILE, T=HT·PT·NT.
- Tile address: addr = (h·PT+p)·NT+n. Iteration order is n fastest, then p, then h. h_idx = addr / (PT·NT).
- Reset: all outputs 0, state FLUSH, counters cleared, err_o cleared. Reset mid-pass abandons the pass; no done_o is produced.
- FLUSH: lasts RD_LAT+M_LAT cycles after rstn deasserts. mul_valid_i is ignored (no wr_en_o, no err), because the multiplier has no reset and stray valids may emerge. start_i is ignored. Then go to IDLE.
- IDLE: on start_i=1, go to ISSUE. Issue counter is 0.
- ISSUE: each cycle with hold_i=0, assert rd_en_o with rd_addr_o=issue count, then increment. hold_i=1 gives rd_en_o=0 with no address advance. After issuing address T-1, go to DRAIN. The first rd_en_o occurs the cycle after start is accepted.
- Address/valid pipe: a (valid, addr, h_idx) shift register of depth RD_LAT+M_LAT.
  - mul_valid_o and h_idx_o are taken at tap RD_LAT.
  - wr_en_o = mul_valid_i and pipe-tail valid; wr_addr_o = pipe-tail addr. Both are combinational from mul_valid_i, so wr_en_o is high the same cycle as mul_valid_i.
- In-flight counter: +1 on rd_en_o, −1 on wr_en_o; both in the same cycle gives net 0.
- DRAIN: when the in-flight count is 0, go to DONE.
- DONE: done_o=1 for one cycle, busy_o still 1, then IDLE.
- start_i outside IDLE is ignored; it is not queued.
- err_o (sticky until reset) sets when, outside FLUSH:
  - mul_valid_i differs from the pipe-tail valid, or
  - start_i is high in IDLE while the in-flight count is nonzero (cannot occur in a correct design; assertion-grade).
- Timing with no hold: rd_en at cycles s+1..s+T, wr_en at s+1+RD_LAT+M_LAT .. s+T+RD_LAT+M_LAT, done_o the cycle after the last wr_en.

Decomposition:
- Shared package ssm_ctrl_pkg holds:
  - state enum {FLUSH, IDLE, ISSUE, DRAIN, DONE}
  - tile-count/width helper functions (clog2, T, HT)
  - tiling defaults shared with dAh_mul
- One sub-module: tag_pipe, a parameterised valid+payload shift register with a mid tap and a tail tap, reused for the mul_valid/h_idx alignment and the write-back address.

Test Plan:
Common settings: H_TOTAL=2, P_TOTAL=2, N_TOTAL=4, H_TILE=1, P_TILE=1, N_TILE=2 (T=8), M_LAT=6, RD_LAT=1. Bench model of dAh_mul: valid delayed 6 cycles.
- Basic pass, start at cycle 0 (post-flush): rd_en cycles 1–8 with addr 0..7. mul_valid cycles 2–9 with h_idx 0,0,0,0,1,1,1,1. wr_en cycles 8–15 with addr 0..7. done_o at cycle 16. busy_o cycles 1–16.
- hold_i=1 at cycles 3–4: rd_en addresses 0,1, gap, then 2..7 at cycles 5–10. wr addresses still 0..7 in order. done_o at cycle 18.
- Reset release, model emits mul_valid_i at cycle 2 of FLUSH: no wr_en_o and err_o=0. start_i during FLUSH is ignored. start after 7 flush cycles runs normally.
- start_i pulsed again at cycle 5 of a pass: ignored, exactly 8 wr_en, a single done_o.
- Fault: model delays one valid by an extra cycle → err_o=1 from that cycle, held until rstn=0.
- rstn=0 at cycle 6 mid-pass: outputs 0 next cycle, no done_o. A new start after flush yields a full clean pass with addresses 0..7.
